chord_sequencer: RTL and testbench
==================================

Name: chord_sequencer

Overview:
- Reads song entries from a synchronous song ROM and drives the note/duration/new_note interface of the chords synthesizer.
- Consecutive note-only entries become stacked chord tones. Note-and-wait and rest entries hold time for a number of beats.
- Sits between the song ROM and chords, sharing the beat tick and play control.

Parameters:
- ADDR_WIDTH, 7, total ROM address width.
- SONG_BITS, 2, upper address bits selecting the song; index width IW = ADDR_WIDTH-SONG_BITS (default 5, i.e. 32 entries per song).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- play  in  1  high = run; low = freeze in place
- song  in  SONG_BITS  song select
- beat  in  1  one-cycle beat tick
- rom_data  in  16  ROM word; valid the cycle after rom_addr is presented
- rom_addr  out  ADDR_WIDTH  registered, equal to {song_latched, index}
- note  out  6  note code to chords
- duration  out  6  duration in beats to chords
- new_note  out  1  one-cycle strobe; note and duration are valid while it is high
- song_done  out  1  level; high after the end marker or index wrap, until restart

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high.
- Reset: returns to IDLE. note=0, duration=0, new_note=0, song_done=0, rom_addr=0, index=0, beat count=0. Reset mid-song aborts immediately, with no further strobes.
- ROM entry fields:
  - [15:14] type: 00 = note (issue, no wait); 01 = note+wait (issue, then wait duration beats); 10 = rest (wait duration beats, no issue); 11 = end of song.
  - [11:6] note; [5:0] duration; [13:12] ignored.
- States: IDLE, FETCH, ROMWAIT, DECODE, ISSUE, GAP, WAIT_BEATS, DONE.
- IDLE: when play=1, latch song, set index=0, go to FETCH.
- FETCH: rom_addr={song_latched,index}. Next state ROMWAIT.
- ROMWAIT: rom_data becomes valid at the end of this cycle. Next state DECODE.
- DECODE:
  - type 00/01: load note and duration registers, go to ISSUE.
  - type 10: load beat count = duration, go to WAIT_BEATS.
  - type 11: go to DONE.
- ISSUE: new_note=1 for exactly this cycle. Next state GAP.
- GAP: new_note=0, which guarantees at least one idle cycle between strobes.
  - type 00: advance.
  - type 01: load count = duration, go to WAIT_BEATS.
- WAIT_BEATS: decrement the count on each beat. Advance when count reaches 0. A count loaded as 0 advances on the next cycle with no beat required. Beats arriving in any other state are ignored.
- Advance: index+1, then FETCH. If index was 2^IW-1 (no end marker found), go to DONE instead of wrapping.
- DONE: song_done=1 and stays there. Restart requires play=0 then play=1, or a song change; either returns to FETCH with index=0 and song_done=0.
- note and duration hold their last issued values outside ISSUE.
- play=0 in any non-IDLE state: freeze state, index and count. No strobe; beats are not counted. If play falls during ISSUE, the strobe completes this cycle and the freeze applies from GAP onward.
- Song change: if song ≠ song_latched while play=1, the next cycle re-latches song, sets index=0, clears the count and song_done, and goes to FETCH. This overrides all other transitions. A pending ISSUE is dropped.
- Latency: if play is first sampled high in cycle N from IDLE, rom_addr is updated in N+1, DECODE is N+3, and new_note is high in N+4. Back-to-back type-00 entries give strobes 6 cycles apart.

Test Plan:
- Chord stack: song 0 = {00/37/4, 00/41/4, 01/44/4, 11}; play=1 at cycle N. Expect strobes at N+4, N+10, N+16 carrying (37,4), (41,4), (44,4). After the 4th beat following N+17, song_done=1 and no further strobes.
- Rest and zero duration: {10/x/2, 01/37/0, 11}. Expect no strobe until 2 beats have passed. Then one strobe with (37,0), with the fetch of the next entry following without any beat. Then song_done=1.
- Freeze: drop play for 20 cycles during WAIT_BEATS with 3 beats pulsed. Expect the count unchanged, no strobe and rom_addr held. The remaining beats resume after play=1.
- Song change mid-wait: switch song 0→1 during WAIT_BEATS. Expect rom_addr = {1,0} on the next cycle and a first strobe carrying song 1's entry 0. Any pending song 0 note is never issued.
- Index wrap: song 3 filled with 32 type-00 entries and no end marker. Expect 32 strobes, then song_done=1 and rom_addr never wraps to {3,0}.
- Reset mid-ISSUE: assert reset in a strobe cycle. Expect all outputs 0 on the next cycle and IDLE; the song restarts from index 0 when play is asserted again.

Source files
------------

// File: rtl/chord_sequencer.sv
// Song ROM walker for the chords synthesizer: fetches entries, stacks note-only
// entries as chord tones and holds time for note+wait and rest entries.
module chord_sequencer #(
    parameter int ADDR_WIDTH = 7,
    parameter int SONG_BITS  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  play,
    input  logic [SONG_BITS-1:0]  song,
    input  logic                  beat,
    input  logic [15:0]           rom_data,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [5:0]            note,
    output logic [5:0]            duration,
    output logic                  new_note,
    output logic                  song_done
);

    localparam int IW = ADDR_WIDTH - SONG_BITS;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ROMWAIT,
        DECODE,
        ISSUE,
        GAP,
        WAIT_BEATS,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [SONG_BITS-1:0]  song_q, song_d;
    logic [IW-1:0]         index_q, index_d;
    logic [5:0]            count_q, count_d;
    logic [5:0]            note_q, note_d;
    logic [5:0]            dur_q, dur_d;
    logic                  wait_q, wait_d;
    logic                  done_q, done_d;
    logic                  play_q;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic [1:0]            entry_type;
    logic                  song_change;
    logic                  unused_rom_bits;

    assign entry_type      = rom_data[15:14];
    assign unused_rom_bits = ^rom_data[13:12];

    // Every advance goes through WAIT_BEATS; a note-only entry is simply a zero-beat wait.
    always_comb begin
        state_d     = state_q;
        song_d      = song_q;
        index_d     = index_q;
        count_d     = count_q;
        note_d      = note_q;
        dur_d       = dur_q;
        wait_d      = wait_q;
        done_d      = done_q;
        rom_addr_d  = rom_addr_q;
        song_change = (state_q != IDLE) && play && (song != song_q);

        case (state_q)
            IDLE: begin
                if (play) begin
                    song_d  = song;
                    index_d = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (play) state_d = ROMWAIT;
            end
            ROMWAIT: begin
                if (play) state_d = DECODE;
            end
            DECODE: begin
                if (play) begin
                    case (entry_type)
                        2'b00, 2'b01: begin
                            note_d  = rom_data[11:6];
                            dur_d   = rom_data[5:0];
                            wait_d  = entry_type[0];
                            state_d = ISSUE;
                        end
                        2'b10: begin
                            count_d = rom_data[5:0];
                            state_d = WAIT_BEATS;
                        end
                        default: begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end
                    endcase
                end
            end
            ISSUE: begin
                state_d = GAP;
            end
            GAP: begin
                if (play) begin
                    count_d = wait_q ? dur_q : 6'd0;
                    state_d = WAIT_BEATS;
                end
            end
            WAIT_BEATS: begin
                if (play) begin
                    if (count_q == 6'd0) begin
                        if (index_q == '1) begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            index_d = index_q + 1'b1;
                            state_d = FETCH;
                        end
                    end else if (beat) begin
                        count_d = count_q - 6'd1;
                    end
                end
            end
            DONE: begin
                if (play && !play_q) begin
                    index_d = '0;
                    done_d  = 1'b0;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new song selection wins over everything, including a decoded but unissued note.
        if (song_change) begin
            song_d  = song;
            index_d = '0;
            count_d = '0;
            done_d  = 1'b0;
            note_d  = note_q;
            dur_d   = dur_q;
            state_d = FETCH;
        end

        if (state_d == FETCH) rom_addr_d = {song_d, index_d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            song_q     <= '0;
            index_q    <= '0;
            count_q    <= '0;
            note_q     <= '0;
            dur_q      <= '0;
            wait_q     <= 1'b0;
            done_q     <= 1'b0;
            play_q     <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            song_q     <= song_d;
            index_q    <= index_d;
            count_q    <= count_d;
            note_q     <= note_d;
            dur_q      <= dur_d;
            wait_q     <= wait_d;
            done_q     <= done_d;
            play_q     <= play;
            rom_addr_q <= rom_addr_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign note      = note_q;
    assign duration  = dur_q;
    assign new_note  = (state_q == ISSUE);
    assign song_done = done_q;

endmodule

// File: tb/tb_chord_sequencer.sv
// Self-checking bench for chord_sequencer: behavioural song ROM, strobe scoreboard,
// a table of single-entry songs and hand-written multi-cycle sequences.
module tb_chord_sequencer;

    localparam int ADDR_WIDTH = 7;
    localparam int SONG_BITS  = 2;
    localparam logic [15:0] END_W = 16'hC000;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  play;
    logic [SONG_BITS-1:0]  song;
    logic                  beat;
    logic [15:0]           rom_data;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [5:0]            note;
    logic [5:0]            duration;
    logic                  new_note;
    logic                  song_done;

    logic [15:0] rom [0:127];
    int cyc      = 0;
    int checks   = 0;
    int failures = 0;
    int strobes  = 0;

    typedef struct {
        logic [5:0] note;
        logic [5:0] dur;
        int         cyc;
    } strobe_t;

    typedef struct {
        logic [15:0] entry;
        int          beats;
        bit          strobe;
        logic [5:0]  note;
        logic [5:0]  dur;
    } vec_t;

    strobe_t exp_q[$];
    vec_t    vecs[6];

    chord_sequencer #(.ADDR_WIDTH(ADDR_WIDTH), .SONG_BITS(SONG_BITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .play      (play),
        .song      (song),
        .beat      (beat),
        .rom_data  (rom_data),
        .rom_addr  (rom_addr),
        .note      (note),
        .duration  (duration),
        .new_note  (new_note),
        .song_done (song_done)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data for an address appears after the next rising edge.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rom_data <= rom[rom_addr];
    end

    function automatic logic [15:0] ent(input logic [1:0] t, input logic [5:0] n, input logic [5:0] d);
        return {t, 2'b00, n, d};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d required %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic observe();
        strobe_t e;
        if (new_note === 1'b1) begin
            strobes++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_strobe", 32'(new_note), 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("strobe_note", 32'(note), 32'(e.note));
                checkOutput("strobe_duration", 32'(duration), 32'(e.dur));
                if (e.cyc >= 0) checkOutput("strobe_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseBeat();
        beat = 1'b1;
        tick();
        beat = 1'b0;
    endtask

    task automatic clearRom();
        for (int i = 0; i < 128; i++) rom[i] = END_W;
    endtask

    task automatic resetDut();
        reset = 1'b1;
        play  = 1'b0;
        beat  = 1'b0;
        song  = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic waitDone(input int budget, input string name);
        for (int i = 0; i < budget && song_done !== 1'b1; i++) tick();
        checkOutput(name, 32'(song_done), 32'd1);
    endtask

    task automatic endTest(input string name);
        checkOutput({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        int n;
        int base;
        clearRom();
        rom[64] = v.entry;
        rom[65] = END_W;
        resetDut();
        base = strobes;
        n    = cyc;
        if (v.strobe) exp_q.push_back('{v.note, v.dur, n + 4});
        song = 2'd2;
        play = 1'b1;
        repeat (20) tick();
        if (v.beats > 0) begin
            checkOutput($sformatf("vec%0d_wait_before_beats", idx), 32'(song_done), 32'd0);
            repeat (v.beats - 1) begin
                pulseBeat();
                tick();
            end
            repeat (6) tick();
            checkOutput($sformatf("vec%0d_wait_last_beat", idx), 32'(song_done), 32'd0);
            pulseBeat();
        end
        waitDone(40, $sformatf("vec%0d_done", idx));
        checkOutput($sformatf("vec%0d_strobes", idx), 32'(strobes - base), 32'(v.strobe));
        endTest($sformatf("vec%0d", idx));
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int m;
        int base;
        int wraps;

        vecs[0] = '{ent(2'b00, 6'd37, 6'd4), 0, 1'b1, 6'd37, 6'd4};
        vecs[1] = '{ent(2'b01, 6'd20, 6'd3), 3, 1'b1, 6'd20, 6'd3};
        vecs[2] = '{ent(2'b10, 6'd9,  6'd2), 2, 1'b0, 6'd0,  6'd0};
        vecs[3] = '{END_W,                   0, 1'b0, 6'd0,  6'd0};
        vecs[4] = '{ent(2'b01, 6'd63, 6'd0), 0, 1'b1, 6'd63, 6'd0};
        vecs[5] = '{16'h303F,                0, 1'b1, 6'd0,  6'd63};

        clearRom();
        resetDut();
        checkOutput("reset_note", 32'(note), 32'd0);
        checkOutput("reset_duration", 32'(duration), 32'd0);
        checkOutput("reset_new_note", 32'(new_note), 32'd0);
        checkOutput("reset_song_done", 32'(song_done), 32'd0);
        checkOutput("reset_rom_addr", 32'(rom_addr), 32'd0);

        for (int i = 0; i < 6; i++) applyStimulus(i, vecs[i]);

        $display("[TB] chord stack");
        clearRom();
        rom[0] = ent(2'b00, 6'd37, 6'd4);
        rom[1] = ent(2'b00, 6'd41, 6'd4);
        rom[2] = ent(2'b01, 6'd44, 6'd4);
        resetDut();
        base = strobes;
        n    = cyc;
        exp_q.push_back('{6'd37, 6'd4, n + 4});
        exp_q.push_back('{6'd41, 6'd4, n + 10});
        exp_q.push_back('{6'd44, 6'd4, n + 16});
        play = 1'b1;
        repeat (20) tick();
        checkOutput("chord_waiting", 32'(song_done), 32'd0);
        repeat (3) begin
            pulseBeat();
            tick();
        end
        repeat (8) tick();
        checkOutput("chord_after_3_beats", 32'(song_done), 32'd0);
        pulseBeat();
        waitDone(20, "chord_done");
        repeat (15) tick();
        checkOutput("chord_strobes", 32'(strobes - base), 32'd3);
        checkOutput("chord_done_held", 32'(song_done), 32'd1);
        endTest("chord");

        $display("[TB] rest and zero duration");
        clearRom();
        rom[32] = ent(2'b10, 6'd5, 6'd2);
        rom[33] = ent(2'b01, 6'd37, 6'd0);
        resetDut();
        base = strobes;
        exp_q.push_back('{6'd37, 6'd0, -1});
        song = 2'd1;
        play = 1'b1;
        repeat (15) tick();
        checkOutput("rest_no_strobe_0", 32'(strobes - base), 32'd0);
        pulseBeat();
        repeat (8) tick();
        checkOutput("rest_no_strobe_1", 32'(strobes - base), 32'd0);
        pulseBeat();
        waitDone(30, "rest_done");
        checkOutput("rest_strobes", 32'(strobes - base), 32'd1);
        endTest("rest");

        $display("[TB] freeze");
        clearRom();
        rom[0] = ent(2'b01, 6'd10, 6'd5);
        rom[1] = ent(2'b00, 6'd11, 6'd1);
        resetDut();
        base = strobes;
        n    = cyc;
        exp_q.push_back('{6'd10, 6'd5, n + 4});
        exp_q.push_back('{6'd11, 6'd1, -1});
        play = 1'b1;
        repeat (10) tick();
        pulseBeat();
        play = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 3 || i == 9 || i == 15) pulseBeat();
            else tick();
        end
        checkOutput("freeze_rom_addr", 32'(rom_addr), 32'd0);
        checkOutput("freeze_strobes", 32'(strobes - base), 32'd1);
        play = 1'b1;
        repeat (3) begin
            pulseBeat();
            tick();
        end
        repeat (10) tick();
        checkOutput("freeze_count_kept", 32'(strobes - base), 32'd1);
        pulseBeat();
        for (int i = 0; i < 20 && (strobes - base) < 2; i++) tick();
        checkOutput("freeze_resumed", 32'(strobes - base), 32'd2);
        waitDone(20, "freeze_done");
        endTest("freeze");

        $display("[TB] song change mid-wait");
        clearRom();
        rom[0]  = ent(2'b01, 6'd12, 6'd3);
        rom[1]  = ent(2'b00, 6'd13, 6'd2);
        rom[32] = ent(2'b00, 6'd50, 6'd7);
        resetDut();
        base = strobes;
        n    = cyc;
        exp_q.push_back('{6'd12, 6'd3, n + 4});
        play = 1'b1;
        repeat (10) tick();
        m = cyc;
        exp_q.push_back('{6'd50, 6'd7, m + 4});
        song = 2'd1;
        tick();
        checkOutput("songchg_rom_addr", 32'(rom_addr), 32'd32);
        waitDone(30, "songchg_done");
        checkOutput("songchg_strobes", 32'(strobes - base), 32'd2);
        endTest("songchg");

        $display("[TB] index wrap");
        clearRom();
        for (int i = 0; i < 32; i++) rom[96 + i] = ent(2'b00, 6'(i + 1), 6'(31 - i));
        resetDut();
        base  = strobes;
        wraps = 0;
        n     = cyc;
        for (int i = 0; i < 32; i++) exp_q.push_back('{6'(i + 1), 6'(31 - i), n + 4 + 6 * i});
        song = 2'd3;
        play = 1'b1;
        tick();
        checkOutput("wrap_first_addr", 32'(rom_addr), 32'd96);
        for (int i = 0; i < 300 && song_done !== 1'b1; i++) begin
            tick();
            if ((strobes - base) >= 2 && rom_addr == 7'd96) wraps++;
        end
        checkOutput("wrap_done", 32'(song_done), 32'd1);
        repeat (10) begin
            tick();
            if (rom_addr == 7'd96) wraps++;
        end
        checkOutput("wrap_addr_never_wrapped", 32'(wraps), 32'd0);
        checkOutput("wrap_strobes", 32'(strobes - base), 32'd32);
        endTest("wrap");

        $display("[TB] reset mid-issue");
        clearRom();
        rom[0] = ent(2'b00, 6'd33, 6'd1);
        rom[1] = ent(2'b00, 6'd34, 6'd2);
        resetDut();
        base = strobes;
        n    = cyc;
        exp_q.push_back('{6'd33, 6'd1, n + 4});
        play = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        play  = 1'b0;
        tick();
        checkOutput("rst_issue_note", 32'(note), 32'd0);
        checkOutput("rst_issue_duration", 32'(duration), 32'd0);
        checkOutput("rst_issue_new_note", 32'(new_note), 32'd0);
        checkOutput("rst_issue_song_done", 32'(song_done), 32'd0);
        checkOutput("rst_issue_rom_addr", 32'(rom_addr), 32'd0);
        reset = 1'b0;
        repeat (5) tick();
        checkOutput("rst_issue_idle_strobes", 32'(strobes - base), 32'd1);
        n = cyc;
        exp_q.push_back('{6'd33, 6'd1, n + 4});
        exp_q.push_back('{6'd34, 6'd2, n + 10});
        play = 1'b1;
        waitDone(40, "rst_issue_restart_done");
        checkOutput("rst_issue_strobes", 32'(strobes - base), 32'd3);
        endTest("rst_issue");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
